serial_add16_ctrl: RTL and testbench

SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

---
 rtl/serial_add16_ctrl_pkg.sv | 13 +
 rtl/serial_add16_ctrl_adder.sv | 14 +
 rtl/serial_add16_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add16_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add16_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder controller.
package serial_add16_ctrl_pkg;

  localparam int NIB_W  = 4;
  localparam int NIB_SH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add16_ctrl_adder.sv
// Shared 4-bit ripple adder used once per cycle by the serial controller.
module nibble_adder4
  import serial_add16_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add16_ctrl.sv
// Nibble-serial W-bit adder: one 4-bit add per cycle, carry held in a register
// between cycles; results are published only when the last nibble completes.
module serial_add16_ctrl
  import serial_add16_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W    = NIB_W * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    psum_q, psum_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [NIB_W-1:0] add_sum;
  logic             add_cout;
  logic [W-1:0]     fin_psum;

  nibble_adder4 nibble_adder4 (
    .a    (a_q[{idx_q, {NIB_SH{1'b0}}} +: NIB_W]),
    .b    (b_q[{idx_q, {NIB_SH{1'b0}}} +: NIB_W]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    psum_d   = psum_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    fin_psum = psum_q;
    fin_psum[{idx_q, {NIB_SH{1'b0}}} +: NIB_W] = add_sum;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // abort beats any start seen in the same cycle; outputs stay untouched
        if (abort) begin
          state_d = IDLE;
        end else begin
          psum_d  = fin_psum;
          carry_d = add_cout;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST) begin
            sum_d   = fin_psum;
            cout_d  = add_cout;
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (fin_psum[W-1] != a_q[W-1]);
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Directed scoreboard bench for the nibble-serial adder controller.
module tb_serial_add16_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, start, abort, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  serial_add16_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic ec, input int due);
    logic [W:0] r;
    exp_t       e;
    r      = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ea[W-1] == eb[W-1]) && (r[W-1] != ea[W-1]);
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      chk("missing_done", 32'(done), 32'(1));
      e = sb.pop_front();
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lc);
    a     = la;
    b     = lb;
    cin   = lc;
    start = 1'b1;
    push_op(la, lb, lc, cyc + 1 + NIBBLES);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int c;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // first edge with rst low accepts the start
    launch(16'h1234, 16'h4321, 1'b0);
    chk("busy_run", 32'(busy), 32'(1));
    drain(20);
    tick();
    chk("sum_hold", 32'(sum), 32'(16'h5555));
    chk("idle_busy", 32'(busy), 32'(0));

    launch(16'hFFFF, 16'h0001, 1'b0);
    drain(20);
    launch(16'h7FFF, 16'h0001, 1'b0);
    drain(20);

    // start held high: back-to-back operations every 5 cycles
    a     = 16'h0F0F;
    b     = 16'h00F1;
    cin   = 1'b1;
    start = 1'b1;
    c     = cyc;
    push_op(16'h0F0F, 16'h00F1, 1'b1, c + 5);
    push_op(16'h0F0F, 16'h00F1, 1'b1, c + 10);
    push_op(16'h0F0F, 16'h00F1, 1'b1, c + 15);
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) start = 1'b0;
      tick();
      chk("b2b_busy", 32'(busy), 32'((i % 5) != 0));
    end
    drain(10);
    tick();
    chk("b2b_idle", 32'(busy), 32'(0));

    // start during RUN with other operands is ignored
    launch(16'h1111, 16'h2222, 1'b0);
    a     = 16'hAAAA;
    b     = 16'h5555;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    drain(20);

    // abort two cycles into RUN, with start also high
    launch(16'h1234, 16'h4321, 1'b0);
    drain(20);
    a     = 16'h0001;
    b     = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(16'h5555));
    repeat (6) tick();
    chk("abort_sum_late", 32'(sum), 32'(16'h5555));

    // abort in IDLE does not block the start
    abort = 1'b1;
    launch(16'h8000, 16'h8000, 1'b0);
    abort = 1'b0;
    drain(20);

    // asynchronous reset mid-RUN
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_cout", 32'(cout), 32'(0));
    chk("mid_rst_ovf", 32'(ovf), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    launch(16'h7FFF, 16'h0001, 1'b0);
    drain(20);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
